// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared console UART frame constants and FSM encoding
//
// Purpose : definitions common to the console UART transmitter and the
//           future receiver.
// Ports   : none (package).
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS        = 8;
    localparam logic START_LEVEL      = 1'b0;
    localparam logic STOP_LEVEL       = 1'b1;
    localparam logic IDLE_LEVEL       = 1'b1;

    // 100 MHz / 115200 baud
    localparam int   DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/console_uart_tx_if.sv
// rtl/console_uart_tx_if.sv - console byte handshake between Wrapper and UART
//
// Purpose : groups the console output byte handshake.
// Signals : CONSOLE_OUT (8b byte), CONSOLE_OUT_valid (byte offered),
//           CONSOLE_OUT_ready (byte can be taken this cycle).
// Modports: master = byte producer (Wrapper), slave = consumer (UART TX).
interface console_uart_tx_if;

    logic [7:0] CONSOLE_OUT;
    logic       CONSOLE_OUT_valid;
    logic       CONSOLE_OUT_ready;

    modport master (
        output CONSOLE_OUT,
        output CONSOLE_OUT_valid,
        input  CONSOLE_OUT_ready
    );

    modport slave (
        input  CONSOLE_OUT,
        input  CONSOLE_OUT_valid,
        output CONSOLE_OUT_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose : small synchronous FIFO, shared by the console TX and RX paths.
// Ports   : clk, rst (sync active-high), push/push_data, pop/pop_data
//           (pop_data shows the head combinationally), full, empty,
//           count (one bit wider than the pointers).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// rtl/console_uart_tx.sv - 8N1 console UART transmitter with input FIFO
//
// Purpose : buffers console bytes in a FIFO and serialises them LSB first
//           as 8N1 frames on TX.
// Ports   : CLK, RESET (sync active-high), console (slave byte handshake),
//           TX (serial line, idle high, registered), BUSY (frame in
//           progress or bytes queued).
module console_uart_tx
    import console_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    console_uart_tx_if.slave console,
    output logic             TX,
    output logic             BUSY
);

    localparam int              CW        = $clog2(BAUD_DIV + 1);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]   BAUD_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic [7:0]    fifo_head;

    uart_state_t   state, state_n;
    logic [CW-1:0] baud_cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          bit_done;

    assign console.CONSOLE_OUT_ready = !fifo_full && !RESET;
    assign fifo_push = console.CONSOLE_OUT_valid && console.CONSOLE_OUT_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (fifo_push),
        .push_data (console.CONSOLE_OUT),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_done = (baud_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= IDLE_LEVEL;
        end else begin
            state    <= state_n;
            baud_cnt <= cnt_n;
            bit_idx  <= idx_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    // tx_n is the line level of the state being entered, so the registered
    // TX changes on the same edge as the state register.
    always_comb begin
        state_n  = state;
        cnt_n    = baud_cnt;
        idx_n    = bit_idx;
        shift_n  = shift;
        tx_n     = tx_q;
        fifo_pop = 1'b0;

        if (state != IDLE) begin
            cnt_n = bit_done ? BAUD_LOAD : baud_cnt - CW'(1);
        end

        case (state)
            IDLE: begin
                tx_n = IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_head;
                    cnt_n    = BAUD_LOAD;
                    state_n  = START;
                    tx_n     = START_LEVEL;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                        tx_n    = STOP_LEVEL;
                    end else begin
                        idx_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame when bytes wait.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_head;
                        state_n  = START;
                        tx_n     = START_LEVEL;
                    end else begin
                        state_n  = IDLE;
                        tx_n     = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = IDLE_LEVEL;
            end
        endcase
    end

    assign TX   = tx_q;
    assign BUSY = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_console_uart_tx.sv
// tb/tb_console_uart_tx.sv - self-checking bench for console_uart_tx
module tb_console_uart_tx;

    localparam int BAUD4 = 4;

    logic CLK;
    logic RESET;
    logic tx4, busy4, tx1, busy1;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    logic [7:0] sb [$];
    logic       mon_en = 1'b0;
    logic [7:0] mon_got;
    logic [7:0] mon_exp;
    logic       mon_stop;

    console_uart_tx_if if4 ();
    console_uart_tx_if if1 ();

    console_uart_tx #(.BAUD_DIV(BAUD4), .FIFO_DEPTH(4)) dut4 (
        .CLK     (CLK),
        .RESET   (RESET),
        .console (if4),
        .TX      (tx4),
        .BUSY    (busy4)
    );

    console_uart_tx #(.BAUD_DIV(1), .FIFO_DEPTH(4)) dut1 (
        .CLK     (CLK),
        .RESET   (RESET),
        .console (if1),
        .TX      (tx1),
        .BUSY    (busy1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Frame decoder for dut4: samples the first cycle of every bit period.
    always begin
        @(negedge CLK);
        if (mon_en && tx4 === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD4) @(negedge CLK);
                mon_got[i] = tx4;
            end
            repeat (BAUD4) @(negedge CLK);
            mon_stop = tx4;
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rx_byte: got %02h, required no frame", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h, required %02h", mon_got, mon_exp);
                end
            end
            vectors++;
            if (mon_stop !== 1'b1) begin
                errors++;
                $display("FAIL rx_stop: got %b, required 1", mon_stop);
            end
        end
    end

    task automatic wait_drain4(input int budget);
        int n = 0;
        while ((busy4 !== 1'b0 || sb.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (busy4 !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: busy %b pending %0d, required busy 0 pending 0", busy4, sb.size());
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        if4.CONSOLE_OUT_valid = 1'b0;
        if4.CONSOLE_OUT = 8'h00;
        if1.CONSOLE_OUT_valid = 1'b0;
        if1.CONSOLE_OUT = 8'h00;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({tx4, busy4, if4.CONSOLE_OUT_ready} !== 3'b100) begin
            errors++;
            $display("FAIL reset_dut4: tx/busy/ready %b, required 100", {tx4, busy4, if4.CONSOLE_OUT_ready});
        end
        vectors++;
        if ({tx1, busy1, if1.CONSOLE_OUT_ready} !== 3'b100) begin
            errors++;
            $display("FAIL reset_dut1: tx/busy/ready %b, required 100", {tx1, busy1, if1.CONSOLE_OUT_ready});
        end
        RESET = 1'b0;
        @(negedge CLK);
        vectors++;
        if (if4.CONSOLE_OUT_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b, required 1", if4.CONSOLE_OUT_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_byte;
        logic [9:0] exp_bits = 10'b1010000010; // bit k = level of symbol k
        int busy_hi = 0;
        if4.CONSOLE_OUT = 8'h41;
        if4.CONSOLE_OUT_valid = 1'b1;
        sb.push_back(8'h41);
        @(negedge CLK);
        if4.CONSOLE_OUT_valid = 1'b0;
        vectors++;
        if (tx4 !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: tx %b after accept, required 1", tx4);
        end
        @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < BAUD4; j++) begin
                vectors++;
                if (tx4 !== exp_bits[k]) begin
                    errors++;
                    $display("FAIL single_tx: symbol %0d cycle %0d got %b, required %b", k, j, tx4, exp_bits[k]);
                end
                if (busy4 === 1'b1) busy_hi++;
                @(negedge CLK);
            end
        end
        vectors++;
        if (busy_hi != 40) begin
            errors++;
            $display("FAIL single_busy: busy cycles %0d, required 40", busy_hi);
        end
        vectors++;
        if ({tx4, busy4} !== 2'b10) begin
            errors++;
            $display("FAIL single_end: tx/busy %b, required 10", {tx4, busy4});
        end
        wait_drain4(200);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3] = '{8'h50, 8'h41, 8'h0D};
        int t_acc = 0;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            if4.CONSOLE_OUT = bytes[i];
            if4.CONSOLE_OUT_valid = 1'b1;
            sb.push_back(bytes[i]);
            @(negedge CLK);
            if (i == 0) t_acc = cyc;
        end
        if4.CONSOLE_OUT_valid = 1'b0;
        while (busy4 === 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (cyc - t_acc != 1 + 30 * BAUD4) begin
            errors++;
            $display("FAIL b2b_length: activity %0d cycles, required %0d", cyc - t_acc, 1 + 30 * BAUD4);
        end
        wait_drain4(200);
    endtask

    task automatic test_full_fifo;
        int  acc = 0;
        int  first_drop = -1;
        int  guard = 0;
        logic ok;
        logic prev_ready = 1'b1;
        logic prev_tx = 1'b1;
        if4.CONSOLE_OUT = 8'h00;
        if4.CONSOLE_OUT_valid = 1'b1;
        while (acc < 10 && guard < 3000) begin
            ok = if4.CONSOLE_OUT_ready;
            if (!ok && first_drop < 0) first_drop = acc;
            if (ok && !prev_ready) begin
                vectors++;
                if ({prev_tx, tx4} !== 2'b10) begin
                    errors++;
                    $display("FAIL full_ready_rise: prev_tx/tx %b, required 10", {prev_tx, tx4});
                end
            end
            if (ok) begin
                sb.push_back(if4.CONSOLE_OUT);
                acc++;
            end
            prev_ready = ok;
            prev_tx = tx4;
            @(negedge CLK);
            guard++;
            if (ok) begin
                if4.CONSOLE_OUT = if4.CONSOLE_OUT + 8'd1;
                if (acc == 10) if4.CONSOLE_OUT_valid = 1'b0;
            end
        end
        if4.CONSOLE_OUT_valid = 1'b0;
        vectors++;
        if (acc != 10) begin
            errors++;
            $display("FAIL full_accepts: accepted %0d, required 10", acc);
        end
        vectors++;
        if (first_drop != 5) begin
            errors++;
            $display("FAIL full_first_drop: accepted %0d before ready fell, required 5", first_drop);
        end
        wait_drain4(1000);
    endtask

    task automatic test_reset_mid_frame;
        int t_acc = 0;
        int low_seen = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if4.CONSOLE_OUT = 8'hF0 + 8'(i);
            if4.CONSOLE_OUT_valid = 1'b1;
            @(negedge CLK);
            if (i == 0) t_acc = cyc;
        end
        if4.CONSOLE_OUT_valid = 1'b0;
        while (cyc < t_acc + 18) @(negedge CLK);
        vectors++;
        if (tx4 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bit3: tx %b, required 0", tx4);
        end
        RESET = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({tx4, busy4, if4.CONSOLE_OUT_ready} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_state: tx/busy/ready %b, required 100", {tx4, busy4, if4.CONSOLE_OUT_ready});
        end
        RESET = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) low_seen++;
        end
        vectors++;
        if (low_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_discard: %0d active cycles after reset, required 0", low_seen);
        end
        mon_en = 1'b1;
        if4.CONSOLE_OUT = 8'h3C;
        if4.CONSOLE_OUT_valid = 1'b1;
        sb.push_back(8'h3C);
        @(negedge CLK);
        if4.CONSOLE_OUT_valid = 1'b0;
        wait_drain4(200);
    endtask

    task automatic test_min_divider;
        logic [9:0] exp_bits = 10'b1101001010;
        if1.CONSOLE_OUT = 8'hA5;
        if1.CONSOLE_OUT_valid = 1'b1;
        @(negedge CLK);
        if1.CONSOLE_OUT_valid = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (tx1 !== exp_bits[k]) begin
                errors++;
                $display("FAIL div1_tx: cycle %0d got %b, required %b", k, tx1, exp_bits[k]);
            end
            @(negedge CLK);
        end
        vectors++;
        if ({tx1, busy1} !== 2'b10) begin
            errors++;
            $display("FAIL div1_end: tx/busy %b, required 10", {tx1, busy1});
        end
    endtask

    task automatic test_push_pop_same_cycle;
        int t_acc = 0;
        int acc = 0;
        int guard = 0;
        if4.CONSOLE_OUT = 8'h11;
        if4.CONSOLE_OUT_valid = 1'b1;
        sb.push_back(8'h11);
        @(negedge CLK);
        t_acc = cyc;
        if4.CONSOLE_OUT = 8'h22;
        sb.push_back(8'h22);
        @(negedge CLK);
        if4.CONSOLE_OUT_valid = 1'b0;
        while (cyc < t_acc + 40) @(negedge CLK);
        if4.CONSOLE_OUT = 8'h33;
        if4.CONSOLE_OUT_valid = 1'b1;
        sb.push_back(8'h33);
        @(negedge CLK);
        if4.CONSOLE_OUT_valid = 1'b0;
        vectors++;
        if (tx4 !== 1'b0) begin
            errors++;
            $display("FAIL pp_contiguous: tx %b at second frame start, required 0", tx4);
        end
        // One byte is held now; room for exactly three more proves the count.
        if4.CONSOLE_OUT = 8'h44;
        if4.CONSOLE_OUT_valid = 1'b1;
        while (if4.CONSOLE_OUT_ready === 1'b1 && guard < 10) begin
            sb.push_back(if4.CONSOLE_OUT);
            acc++;
            @(negedge CLK);
            if4.CONSOLE_OUT = if4.CONSOLE_OUT + 8'd1;
            guard++;
        end
        if4.CONSOLE_OUT_valid = 1'b0;
        vectors++;
        if (acc != 3) begin
            errors++;
            $display("FAIL pp_count: free slots %0d, required 3", acc);
        end
        wait_drain4(1000);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_min_divider();
        test_push_pop_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/console_uart_tx.md
# console_uart_tx

Serializes bytes that the processor Wrapper presents on its console output port onto an 8N1 asynchronous serial line toward the PC. It sits between the Wrapper's CONSOLE_OUT / CONSOLE_OUT_valid / CONSOLE_OUT_ready handshake and the board's UART TX pin. A small FIFO absorbs bursts of console writes, so the processor stalls only when the FIFO is full.

## Interface

**Parameters**
- BAUD_DIV, 868: CLK cycles per serial bit (100 MHz / 115200); legal range 1..65535.
- FIFO_DEPTH, 4: byte entries; must be a power of two, at least 2.

**Ports**
- CLK, input, 1: single clock; all state changes on the rising edge.
- RESET, input, 1: synchronous, active-high.
- CONSOLE_OUT, input, 8: byte offered by the Wrapper.
- CONSOLE_OUT_valid, input, 1: CONSOLE_OUT holds a byte to send.
- CONSOLE_OUT_ready, output, 1: FIFO can accept a byte this cycle.
- TX, output, 1: serial line; idle high.
- BUSY, output, 1: frame in progress or FIFO non-empty.

## Operation

- **Accept:** a byte is pushed on a rising CLK edge where CONSOLE_OUT_valid && CONSOLE_OUT_ready.
  - CONSOLE_OUT_ready = !full && !RESET (combinational from the registered occupancy count).
  - Holding valid high across multiple accepts pushes one byte per accepting cycle.
- **FSM states:**
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter, and go to START.
  - START: TX=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: TX = shift[0]. Send LSB first, shifting right every BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: TX=1 for BAUD_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Counters:**
  - Baud counter is $clog2(BAUD_DIV+1) bits wide. It counts down from BAUD_DIV-1 to 0; a bit ends when the count is 0.
  - Bit index is 3 bits.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
- **Simultaneous push and pop:** occupancy is unchanged, and the data ordering is preserved.
- **Push when full:** cannot occur, because ready=0. A pop from a full FIFO raises ready on the following cycle.
- **Reset:** reset mid-frame aborts the frame immediately and discards all FIFO contents.
- **BUSY:** equals (state != IDLE) || (count != 0).

## Timing

- **Reset values:** TX=1, BUSY=0, state=IDLE, FIFO empty. CONSOLE_OUT_ready=0 while RESET=1 and 1 on the first cycle after release.
- **Latency:** a byte accepted at edge N into an empty, idle block is popped at edge N+1, and TX falls after edge N+1.
- **Frame length:** exactly 10×BAUD_DIV cycles. Back-to-back frames are contiguous.
- **BAUD_DIV=1:** every state lasts exactly one cycle, and a frame is 10 cycles.
- **Output timing:** TX is driven from a flop (glitch-free). No combinational path from CONSOLE_OUT to TX.

## Structure

- **Shared package `console_pkg`:**
  - FSM state encoding: IDLE, START, DATA, STOP.
  - Frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
  - Default BAUD_DIV.
  - The future console_uart_rx reuses this package.
- **Sub-module `sync_fifo`:**
  - Parameterized width and depth, with push/pop/full/empty/count.
  - Same CLK and synchronous RESET.
  - Reusable for the RX direction.
- **Remaining logic:** FSM, baud counter and shift register in console_uart_tx.

## Test plan

1. **Single byte.** BAUD_DIV=4; one-cycle valid with CONSOLE_OUT=0x41 after reset.
   - TX must be 0,1,0,0,0,0,0,1,0,1, each held for 4 cycles, starting 1 cycle after accept.
   - BUSY must be high for exactly 40 cycles.
2. **Back-to-back.** Push 0x50, 0x41, 0x0D on consecutive cycles.
   - All three frames must be contiguous, with no idle gap: 30×BAUD_DIV cycles of activity.
   - Decoded bytes must be in the same order.
3. **Full FIFO.** FIFO_DEPTH=4, valid held high with incrementing data 0x00..0x09.
   - Exactly 5 bytes are accepted before ready first drops (4 in the FIFO plus 1 popped).
   - Ready reasserts one cycle after each pop.
   - All 10 bytes are received in order, with none lost or duplicated.
4. **Reset mid-frame.** Assert RESET during DATA bit 3 with 2 bytes queued.
   - On the next edge TX=1, BUSY=0 and the FIFO is empty; the queued bytes are never sent.
   - A byte pushed after release transmits correctly.
5. **Minimum divider.** BAUD_DIV=1 with byte 0xA5.
   - TX must be 0,1,0,1,0,0,1,0,1,1 over 10 consecutive cycles.
6. **Push and pop in the same cycle.** Push a new byte on the same edge as the STOP→START pop.
   - Count is unchanged, and both bytes arrive in order.
